// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared CPU types for the fetch stage.
//   word_t        : 32-bit machine word (instructions and addresses)
//   fetch_state_t : fetch FSM states (RUN, PEND, HALTED)
//   ifid_t        : IF/ID pipeline register contents
//   next_pc()     : sequential PC increment, wraps modulo 2^32
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,  // fetching sequentially
    PEND   = 2'd1,  // redirect captured, waiting for the in-flight fetch to return
    HALTED = 2'd2   // fetch stopped until reset
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
    logic  valid;
  } ifid_t;

  // An empty IF/ID slot: all fields zero, valid low.
  localparam ifid_t IFID_BUBBLE = '0;

  localparam word_t INSTR_BYTES = 32'd4;

  // Plain 32-bit addition drops the carry, so 32'hFFFFFFFC wraps to 0.
  function automatic word_t next_pc(input word_t pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if -- bundles the fetch stage's cache, hazard and IF/ID signals.
//   icache side : ihit, iload (in)   / iren, iaddr (out)
//   hazard side : stall, flush, redirect_en, redirect_pc, halt (in)
//   IF/ID side  : instr_out, npc_out, valid_out, halted (out)
// master = the fetch stage, slave = its environment (cache, hazard unit, decode).
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iren;
  word_t iaddr;
  logic  stall;
  logic  flush;
  logic  redirect_en;
  word_t redirect_pc;
  logic  halt;
  word_t instr_out;
  word_t npc_out;
  logic  valid_out;
  logic  halted;

  modport master (
    input  ihit, iload, stall, flush, redirect_en, redirect_pc, halt,
    output iren, iaddr, instr_out, npc_out, valid_out, halted
  );

  modport slave (
    output ihit, iload, stall, flush, redirect_en, redirect_pc, halt,
    input  iren, iaddr, instr_out, npc_out, valid_out, halted
  );

endinterface

// File: rtl/fetch_stage_ifid_latch.sv
// ifid_latch -- IF/ID pipeline register.
//   clk, rst : clock, asynchronous active-high reset (clears to a bubble)
//   load     : capture d
//   bubble   : clear to an empty slot; overrides load
//   d, q     : register input / contents
// With neither load nor bubble asserted the contents hold (stall).
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= IFID_BUBBLE;
    else if (bubble) q <= IFID_BUBBLE;
    else if (load)   q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch: PC register, redirect handling and halt.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_stage_if.master (icache request/response, hazard
//              controls, IF/ID outputs, halted status)
// Per-cycle priority: reset > redirect > halt > flush > stall > normal.
// A redirect that arrives while a fetch is outstanding is parked in pend_pc
// (PEND) until the cache answers; that answer is discarded.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_t state, state_n;
  word_t        pc, pc_n;
  word_t        pend_pc, pend_pc_n;
  logic         ifid_load, ifid_bubble;
  ifid_t        ifid_d, ifid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pc      <= PC_RESET;
      pend_pc <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_pc_n;
    end
  end

  assign ifid_d = '{instr: bus.iload, npc: next_pc(pc), valid: 1'b1};

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pend_pc_n   = pend_pc;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;

    unique case (state)
      RUN: begin
        if (bus.redirect_en) begin
          ifid_bubble = 1'b1;
          if (bus.ihit) begin
            pc_n = bus.redirect_pc;       // returning word is wrong-path
          end else begin
            pend_pc_n = bus.redirect_pc;  // keep iaddr stable until ihit
            state_n   = PEND;
          end
        end else if (bus.halt) begin
          ifid_bubble = 1'b1;
          state_n     = HALTED;
        end else begin
          if (bus.ihit && !bus.stall) pc_n = next_pc(pc);
          if (bus.flush)      ifid_bubble = 1'b1;
          else if (bus.stall) ;            // hold IF/ID
          else if (bus.ihit)  ifid_load   = 1'b1;
          else                ifid_bubble = 1'b1;
        end
      end

      PEND: begin
        ifid_bubble = 1'b1;
        if (bus.redirect_en) begin
          if (bus.ihit) begin
            pc_n    = bus.redirect_pc;
            state_n = RUN;
          end else begin
            pend_pc_n = bus.redirect_pc;  // latest redirect wins
          end
        end else if (bus.halt) begin
          state_n = HALTED;
        end else if (bus.ihit) begin
          pc_n    = pend_pc;
          state_n = RUN;
        end
      end

      HALTED: ;  // frozen; IF/ID already holds the bubble from the halt cycle

      default: state_n = RUN;
    endcase
  end

  ifid_latch u_ifid (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign bus.iren      = (state != HALTED);
  assign bus.iaddr     = pc;
  assign bus.halted    = (state == HALTED);
  assign bus.instr_out = ifid_q.instr;
  assign bus.npc_out   = ifid_q.npc;
  assign bus.valid_out = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- scoreboard bench for fetch_stage.
// Stimulus is applied on the falling edge; a reference model computes the
// outputs expected after the next rising edge and queues them. A monitor
// compares the DUT against the queue head just after each rising edge.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  localparam word_t PC_RESET = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.PC_RESET(PC_RESET)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks architectural facts only: where fetch points, whether a redirect
  // target is waiting for the outstanding fetch, whether fetch has stopped,
  // and what IF/ID holds.
  word_t m_pc, m_target, m_instr, m_npc;
  logic  m_waiting, m_stopped, m_valid;

  typedef struct {
    word_t iaddr;
    logic  iren;
    word_t instr;
    word_t npc;
    logic  valid;
    logic  halted;
  } exp_t;

  exp_t sb[$];

  task automatic model_reset();
    m_pc = PC_RESET; m_target = '0; m_waiting = 1'b0; m_stopped = 1'b0;
    m_instr = '0; m_npc = '0; m_valid = 1'b0;
  endtask

  task automatic model_bubble();
    m_instr = '0; m_npc = '0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic ihit, input word_t iload, input logic stall,
                            input logic flush, input logic redir, input word_t rpc,
                            input logic halt);
    if (m_stopped) begin
      // nothing changes until reset
    end else if (redir) begin
      model_bubble();
      if (ihit) begin m_pc = rpc; m_waiting = 1'b0; end
      else      begin m_target = rpc; m_waiting = 1'b1; end
    end else if (halt) begin
      model_bubble();
      m_stopped = 1'b1;
    end else if (m_waiting) begin
      model_bubble();
      if (ihit) begin m_pc = m_target; m_waiting = 1'b0; end
    end else begin
      word_t seq = m_pc + 32'd4;
      if (flush)      model_bubble();
      else if (stall) ;
      else if (ihit)  begin m_instr = iload; m_npc = seq; m_valid = 1'b1; end
      else            model_bubble();
      if (ihit && !stall) m_pc = seq;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic ihit, input word_t iload, input logic stall,
                      input logic flush, input logic redir, input word_t rpc,
                      input logic halt);
    exp_t e;
    @(negedge clk);
    bus.ihit = ihit; bus.iload = iload; bus.stall = stall; bus.flush = flush;
    bus.redirect_en = redir; bus.redirect_pc = rpc; bus.halt = halt;
    model_step(ihit, iload, stall, flush, redir, rpc, halt);
    e.iaddr = m_pc; e.iren = !m_stopped; e.instr = m_instr; e.npc = m_npc;
    e.valid = m_valid; e.halted = m_stopped;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.ihit = 1'b0; bus.iload = '0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.redirect_en = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0;
  endtask

  // Asserts reset away from any clock edge so the clear must be asynchronous.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_iaddr",  bus.iaddr,     PC_RESET);
    check("rst_iren",   bus.iren,      1'b1);
    check("rst_valid",  bus.valid_out, 1'b0);
    check("rst_instr",  bus.instr_out, '0);
    check("rst_npc",    bus.npc_out,   '0);
    check("rst_halted", bus.halted,    1'b0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("first_iaddr", bus.iaddr, PC_RESET);
    check("first_iren",  bus.iren,  1'b1);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("iaddr",     bus.iaddr,     mon_e.iaddr);
      check("iren",      bus.iren,      mon_e.iren);
      check("valid_out", bus.valid_out, mon_e.valid);
      check("instr_out", bus.instr_out, mon_e.instr);
      check("npc_out",   bus.npc_out,   mon_e.npc);
      check("halted",    bus.halted,    mon_e.halted);
    end
  end

  function automatic word_t rand_target();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  // ---------------- test sequence ----------------
  localparam word_t W = 32'h3C01_0010;

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Sequential fetch, then a 3-cycle miss at iaddr 8.
    do_reset();
    repeat (2) step(1, W, 0, 0, 0, '0, 0);
    repeat (3) step(0, '0, 0, 0, 0, '0, 0);
    step(1, 32'h2000_0001, 0, 0, 0, '0, 0);

    // Redirect during a miss, re-redirect while pending, then the late hit.
    step(0, '0, 0, 0, 1, 32'h0000_0100, 0);
    step(0, '0, 0, 0, 1, 32'h0000_0200, 0);
    step(0, '0, 0, 0, 0, '0, 0);
    step(1, 32'hDEAD_BEEF, 0, 0, 0, '0, 0);
    step(1, 32'h1111_2222, 0, 0, 0, '0, 0);

    // Stall and flush together on a hit.
    step(1, 32'h3333_4444, 1, 1, 0, '0, 0);
    step(1, 32'h3333_4444, 1, 0, 0, '0, 0);
    step(1, 32'h5555_6666, 0, 0, 0, '0, 0);

    // Wrap at the top of the address space.
    step(1, '0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    step(1, 32'h7777_8888, 0, 0, 0, '0, 0);

    // Halt with redirect: redirect wins. Halt alone mid-fetch, then inputs ignored.
    step(0, '0, 0, 0, 1, 32'h0000_0040, 1);
    step(1, 32'h9999_AAAA, 0, 0, 0, '0, 0);
    step(0, '0, 0, 0, 0, '0, 1);
    step(1, 32'hBBBB_CCCC, 0, 0, 1, 32'h0000_0800, 0);
    step(1, 32'hBBBB_CCCC, 0, 1, 0, '0, 1);
    do_reset();

    // Reset while a redirect is pending.
    step(0, '0, 0, 0, 1, 32'h0000_0300, 0);
    do_reset();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ((m_stopped && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 6, $urandom(),
             $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
             $urandom_range(0, 9) == 0, rand_target(),
             $urandom_range(0, 39) == 0);
      end
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
